// File: rtl/scan_chain_sequencer_if.sv
// Host-side port bundle of the scan-chain sequencer: control inputs, the
// sampled cycle parameters, and the valid/ready result port with status.
interface scan_chain_sequencer_if #(
    parameter int NUM_IOS = 8,
    parameter int SEL_W   = 9,
    parameter int WS_W    = 8
);
    logic                 enable;
    logic                 continuous;
    logic                 trigger;
    logic [SEL_W-1:0]     active_select;
    logic [WS_W-1:0]      ws_cfg;
    logic [NUM_IOS-1:0]   inputs;
    logic [NUM_IOS-1:0]   outputs;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 sel_err;
    logic [7:0]           overrun_cnt;

    // Host / IO mux side: drives controls and consumes results.
    modport master (
        output enable, continuous, trigger, active_select, ws_cfg, inputs, out_ready,
        input  outputs, out_valid, busy, sel_err, overrun_cnt
    );

    // Sequencer side.
    modport slave (
        input  enable, continuous, trigger, active_select, ws_cfg, inputs, out_ready,
        output outputs, out_valid, busy, sel_err, overrun_cnt
    );
endinterface

// File: rtl/scan_chain_sequencer.sv
// Internal scan-chain driver. One access cycle shifts the host inputs into the
// selected design, latches them, parallel-loads every design's outputs into
// the chain, shifts back only until the selected design's bits have been seen,
// and presents them on a valid/ready port. Chain pins are registered and so
// follow the state that produces them by one clock.
module scan_chain_sequencer #(
    parameter int NUM_DESIGNS = 250,
    parameter int NUM_IOS     = 8,
    parameter int SEL_W       = 9,
    parameter int WS_W        = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    scan_chain_sequencer_if.slave       host,
    output logic                        scan_clk_out,
    output logic                        scan_data_out,
    input  logic                        scan_data_in,
    output logic                        scan_select,
    output logic                        scan_latch_en
);

    localparam int BIT_W = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DESIGNS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_IOS - 1);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        IN_SHIFT_LO   = 4'd1,
        IN_SHIFT_HI   = 4'd2,
        IN_LATCH_WAIT = 4'd3,
        IN_LATCH      = 4'd4,
        OUT_LOAD_PRE  = 4'd5,
        OUT_LOAD      = 4'd6,
        OUT_LOAD_POST = 4'd7,
        OUT_LOAD_CLR  = 4'd8,
        OUT_SHIFT_LO  = 4'd9,
        OUT_SHIFT_HI  = 4'd10,
        OUT_CAP_WAIT  = 4'd11,
        OUT_CAP       = 4'd12
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     osel_q, osel_d;
    logic [WS_W-1:0]      ws_q, ws_d;
    logic [WS_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [SEL_W-1:0]     proj_cnt_q, proj_cnt_d;
    logic [NUM_IOS-1:0]   isr_q, isr_d;
    logic [NUM_IOS-1:0]   osr_q, osr_d;
    logic [NUM_IOS-1:0]   outputs_q, outputs_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 sel_err_q, sel_err_d;
    logic [7:0]           overrun_q, overrun_d;
    logic                 sclk_q, sclk_d;
    logic                 sdo_q, sdo_d;
    logic                 ssel_q, ssel_d;
    logic                 slatch_q, slatch_d;

    logic                 start_s;
    logic                 wait_done_s;
    logic                 bit_last_s;

    // Next-state, datapath and registered-pin computation.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        osel_d      = osel_q;
        ws_d        = ws_q;
        wait_cnt_d  = wait_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        proj_cnt_d  = proj_cnt_q;
        isr_d       = isr_q;
        osr_d       = osr_q;
        outputs_d   = outputs_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        overrun_d   = overrun_q;

        start_s     = (state_q == IDLE) && host.enable && (host.continuous || host.trigger);
        wait_done_s = (wait_cnt_q == ws_q);
        bit_last_s  = (bit_cnt_q == LAST_BIT);

        // Handshake drains the result; a capture in the same cycle overrides below.
        if (out_valid_q && host.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                proj_cnt_d = '0;
                wait_cnt_d = '0;
                if (start_s) begin
                    if (host.active_select > LAST_SEL) begin
                        sel_err_d = 1'b1;
                    end else begin
                        sel_d   = host.active_select;
                        osel_d  = LAST_SEL - host.active_select;
                        ws_d    = host.ws_cfg;
                        isr_d   = host.inputs;
                        state_d = IN_SHIFT_LO;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            IN_SHIFT_LO: begin
                state_d = IN_SHIFT_HI;
            end
            IN_SHIFT_HI: begin
                isr_d = {isr_q[NUM_IOS-2:0], 1'b0};
                if ((proj_cnt_q == sel_q) && bit_last_s) begin
                    // Counters restart so the output shift counts from design 0.
                    bit_cnt_d  = '0;
                    proj_cnt_d = '0;
                    state_d    = IN_LATCH_WAIT;
                end else begin
                    if (bit_last_s) begin
                        bit_cnt_d  = '0;
                        proj_cnt_d = proj_cnt_q + SEL_W'(1);
                    end else begin
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                    end
                    state_d = IN_SHIFT_LO;
                end
            end
            IN_LATCH_WAIT, OUT_LOAD_PRE, OUT_LOAD_POST, OUT_LOAD_CLR, OUT_CAP_WAIT: begin
                if (wait_done_s) begin
                    wait_cnt_d = '0;
                    case (state_q)
                        IN_LATCH_WAIT: state_d = IN_LATCH;
                        OUT_LOAD_PRE:  state_d = OUT_LOAD;
                        OUT_LOAD_POST: state_d = OUT_LOAD_CLR;
                        OUT_LOAD_CLR:  state_d = OUT_SHIFT_LO;
                        OUT_CAP_WAIT:  state_d = OUT_CAP;
                        default:       state_d = IDLE;
                    endcase
                end else begin
                    wait_cnt_d = wait_cnt_q + WS_W'(1);
                end
            end
            IN_LATCH: begin
                state_d = OUT_LOAD_PRE;
            end
            OUT_LOAD: begin
                state_d = OUT_LOAD_POST;
            end
            OUT_SHIFT_LO: begin
                // Only the selected design's bits are kept; earlier designs pass through.
                if (proj_cnt_q == osel_q) begin
                    osr_d = {osr_q[NUM_IOS-2:0], scan_data_in};
                end else begin
                    osr_d = osr_q;
                end
                state_d = OUT_SHIFT_HI;
            end
            OUT_SHIFT_HI: begin
                if ((proj_cnt_q == osel_q) && bit_last_s) begin
                    bit_cnt_d  = '0;
                    proj_cnt_d = '0;
                    state_d    = OUT_CAP_WAIT;
                end else begin
                    if (bit_last_s) begin
                        bit_cnt_d  = '0;
                        proj_cnt_d = proj_cnt_q + SEL_W'(1);
                    end else begin
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                    end
                    state_d = OUT_SHIFT_LO;
                end
            end
            OUT_CAP: begin
                outputs_d   = osr_q;
                out_valid_d = 1'b1;
                if (out_valid_q && !host.out_ready && (overrun_q != 8'hFF)) begin
                    overrun_d = overrun_q + 8'd1;
                end else begin
                    overrun_d = overrun_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d != IDLE);
        sclk_d   = (state_q == IN_SHIFT_HI) || (state_q == OUT_LOAD) || (state_q == OUT_SHIFT_HI);
        ssel_d   = (state_q == OUT_LOAD_PRE) || (state_q == OUT_LOAD) || (state_q == OUT_LOAD_POST);
        slatch_d = (state_q == IN_LATCH);
        // Data is held across the LO/HI pair so it never moves on a scan clock edge.
        if ((state_q == IN_SHIFT_LO) || (state_q == IN_SHIFT_HI)) begin
            sdo_d = isr_q[NUM_IOS-1];
        end else begin
            sdo_d = 1'b0;
        end
    end

    // State and register update; reset aborts any cycle and drops the chain pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            osel_q      <= '0;
            ws_q        <= '0;
            wait_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            proj_cnt_q  <= '0;
            isr_q       <= '0;
            osr_q       <= '0;
            outputs_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sel_err_q   <= 1'b0;
            overrun_q   <= 8'd0;
            sclk_q      <= 1'b0;
            sdo_q       <= 1'b0;
            ssel_q      <= 1'b0;
            slatch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            osel_q      <= osel_d;
            ws_q        <= ws_d;
            wait_cnt_q  <= wait_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            proj_cnt_q  <= proj_cnt_d;
            isr_q       <= isr_d;
            osr_q       <= osr_d;
            outputs_q   <= outputs_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sel_err_q   <= sel_err_d;
            overrun_q   <= overrun_d;
            sclk_q      <= sclk_d;
            sdo_q       <= sdo_d;
            ssel_q      <= ssel_d;
            slatch_q    <= slatch_d;
        end
    end

    assign host.outputs     = outputs_q;
    assign host.out_valid   = out_valid_q;
    assign host.busy        = busy_q;
    assign host.sel_err     = sel_err_q;
    assign host.overrun_cnt = overrun_q;
    assign scan_clk_out     = sclk_q;
    assign scan_data_out    = sdo_q;
    assign scan_select      = ssel_q;
    assign scan_latch_en    = slatch_q;

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Randomized bench for scan_chain_sequencer with a behavioural chain of
// designs and a cycle-level reference model (lengths, pulse counts, results).
module tb_scan_chain_sequencer;

    localparam int ND  = 4;
    localparam int IOS = 8;
    localparam int SW  = 9;
    localparam int WW  = 8;
    localparam int LIM = 2000;
    localparam int L   = ND * IOS;

    logic clk = 1'b0;
    logic reset;
    logic scan_clk_out, scan_data_out, scan_data_in, scan_select, scan_latch_en;

    scan_chain_sequencer_if #(.NUM_IOS(IOS), .SEL_W(SW), .WS_W(WW)) hif ();

    scan_chain_sequencer #(.NUM_DESIGNS(ND), .NUM_IOS(IOS), .SEL_W(SW), .WS_W(WW)) dut (
        .clk           (clk),
        .reset         (reset),
        .host          (hif),
        .scan_clk_out  (scan_clk_out),
        .scan_data_out (scan_data_out),
        .scan_data_in  (scan_data_in),
        .scan_select   (scan_select),
        .scan_latch_en (scan_latch_en)
    );

    always #5 clk = ~clk;

    // Chain model: design d holds bit b at position d*IOS+b; position 0 is fed
    // from scan_data_out and position L-1 returns on scan_data_in.
    logic [L-1:0]   chain;
    logic [IOS-1:0] dout    [ND];
    logic [IOS-1:0] latched [ND];
    int sclk_cnt  = 0;
    int latch_cnt = 0;

    assign scan_data_in = chain[L-1];

    always @(posedge scan_clk_out) begin
        sclk_cnt <= sclk_cnt + 1;
        if (scan_select) begin
            for (int d = 0; d < ND; d++) chain[d*IOS +: IOS] <= dout[d];
        end else begin
            chain <= {chain[L-2:0], scan_data_out};
        end
    end

    always @(posedge scan_latch_en) begin
        latch_cnt <= latch_cnt + 1;
        for (int d = 0; d < ND; d++) latched[d] <= chain[d*IOS +: IOS];
    end

    int vec_cnt = 0;
    int err_cnt = 0;
    bit exp_valid = 1'b0;
    int exp_overrun = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_len(input int ws);
        return 2 * IOS * (ND + 1) + 5 * (ws + 1) + 3;
    endfunction

    task automatic set_douts();
        for (int d = 0; d < ND; d++) dout[d] = IOS'($urandom);
    endtask

    task automatic model_capture();
        if (exp_valid && exp_overrun < 255) exp_overrun++;
        exp_valid = 1'b1;
    endtask

    // Wait until busy drops; returns the number of busy cycles seen.
    task automatic wait_idle(output int len);
        len = 0;
        while (hif.busy && len < LIM) begin
            len++;
            @(negedge clk);
        end
        if (len >= LIM) check_eq("busy_timeout", 32'(len), 32'd0);
    endtask

    task automatic run_cycle(input int sel, input int ws, input logic [IOS-1:0] din,
                             input bit consume, output int len);
        int p0, l0;
        p0 = sclk_cnt;
        l0 = latch_cnt;
        hif.active_select = SW'(sel);
        hif.ws_cfg        = WW'(ws);
        hif.inputs        = din;
        hif.trigger       = 1'b1;
        @(negedge clk);
        hif.trigger       = 1'b0;
        hif.active_select = SW'($urandom_range(0, 7));
        hif.ws_cfg        = WW'($urandom_range(0, 9));
        hif.inputs        = IOS'($urandom);
        wait_idle(len);
        model_capture();
        check_eq("cyc_len",  32'(len), 32'(exp_len(ws)));
        check_eq("outputs",  32'(hif.outputs), 32'(dout[sel]));
        check_eq("valid",    32'(hif.out_valid), 32'(exp_valid));
        check_eq("overrun",  32'(hif.overrun_cnt), 32'(exp_overrun));
        check_eq("latched",  32'(latched[sel]), 32'(din));
        check_eq("sclk_pls", 32'(sclk_cnt - p0), 32'((ND + 1) * IOS + 1));
        check_eq("latch_pls", 32'(latch_cnt - l0), 32'd1);
        if (consume) begin
            hif.out_ready = 1'b1;
            @(negedge clk);
            hif.out_ready = 1'b0;
            exp_valid = 1'b0;
            check_eq("consumed", 32'(hif.out_valid), 32'(exp_valid));
        end
    endtask

    initial begin
        int len, len0, len5, n, p0, ov0;
        reset             = 1'b1;
        hif.enable        = 1'b1;
        hif.continuous    = 1'b0;
        hif.trigger       = 1'b0;
        hif.active_select = '0;
        hif.ws_cfg        = '0;
        hif.inputs        = '0;
        hif.out_ready     = 1'b0;
        set_douts();
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 32'(hif.outputs), 32'd0);
        check_eq("rst_valid",   32'(hif.out_valid), 32'd0);
        check_eq("rst_busy",    32'(hif.busy), 32'd0);
        check_eq("rst_selerr",  32'(hif.sel_err), 32'd0);
        check_eq("rst_overrun", 32'(hif.overrun_cnt), 32'd0);
        check_eq("rst_pins",    32'({scan_clk_out, scan_data_out, scan_select, scan_latch_en}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: design 2, inputs A5, ws 2, design 2 returns 3C.
        dout[2] = 8'h3C;
        run_cycle(2, 2, 8'hA5, 1'b0, len);
        check_eq("t1_len", 32'(len), 32'd98);
        check_eq("t2_out", 32'(hif.outputs), 32'h3C);
        hif.out_ready = 1'b1;
        @(negedge clk);
        hif.out_ready = 1'b0;
        exp_valid = 1'b0;

        // Randomized single-shot cycles, some left unconsumed.
        for (int i = 0; i < 8; i++) begin
            set_douts();
            run_cycle($urandom_range(0, ND - 1), $urandom_range(0, 4), IOS'($urandom),
                      1'($urandom_range(0, 1)), len);
        end

        // Wait-state sensitivity.
        run_cycle(1, 0, 8'h5A, 1'b1, len0);
        run_cycle(1, 5, 8'hC3, 1'b1, len5);
        check_eq("ws_delta", 32'(len5 - len0), 32'd25);

        // enable low: triggers ignored.
        hif.enable  = 1'b0;
        hif.trigger = 1'b1;
        @(negedge clk);
        hif.trigger = 1'b0;
        check_eq("en_low_busy", 32'(hif.busy), 32'd0);
        hif.enable  = 1'b1;

        // Continuous mode, no consumer: three captures, two overruns.
        set_douts();
        ov0 = int'(hif.overrun_cnt);
        hif.active_select = SW'(3);
        hif.ws_cfg        = WW'(1);
        hif.inputs        = 8'h96;
        hif.continuous    = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            wait_idle(len);
            model_capture();
            if (k == 2) hif.continuous = 1'b0;
            check_eq("cont_len", 32'(len), 32'(exp_len(1)));
            @(negedge clk);
            check_eq("cont_gap", 32'(hif.busy), (k < 2) ? 32'd1 : 32'd0);
        end
        check_eq("cont_ovr_delta", 32'(int'(hif.overrun_cnt) - ov0), 32'd2);
        check_eq("cont_overrun", 32'(hif.overrun_cnt), 32'(exp_overrun));
        check_eq("cont_outputs", 32'(hif.outputs), 32'(dout[3]));
        check_eq("cont_latched", 32'(latched[3]), 32'h96);
        hif.out_ready = 1'b1;
        @(negedge clk);
        hif.out_ready = 1'b0;
        exp_valid = 1'b0;

        // Out-of-range select.
        p0 = sclk_cnt;
        hif.active_select = SW'(ND);
        hif.trigger = 1'b1;
        @(negedge clk);
        hif.trigger = 1'b0;
        check_eq("selerr", 32'(hif.sel_err), 32'd1);
        check_eq("selerr_busy", 32'(hif.busy), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("selerr_busy2", 32'(hif.busy), 32'd0);
        check_eq("selerr_sclk", 32'(sclk_cnt - p0), 32'd0);

        // Reset during the output shift (a high-phase cycle: scan clock low).
        set_douts();
        p0 = sclk_cnt;
        hif.active_select = SW'(0);
        hif.ws_cfg = WW'(1);
        hif.inputs = 8'h3F;
        hif.trigger = 1'b1;
        @(negedge clk);
        hif.trigger = 1'b0;
        n = 0;
        while (!((sclk_cnt - p0 >= IOS + 1 + 3) && !scan_clk_out) && n < LIM) begin
            n++;
            @(negedge clk);
        end
        check_eq("rst_reach", 32'(n < LIM), 32'd1);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_busy",    32'(hif.busy), 32'd0);
        check_eq("mid_rst_outputs", 32'(hif.outputs), 32'd0);
        check_eq("mid_rst_valid",   32'(hif.out_valid), 32'd0);
        check_eq("mid_rst_selerr",  32'(hif.sel_err), 32'd0);
        check_eq("mid_rst_pins",    32'({scan_clk_out, scan_data_out, scan_select, scan_latch_en}), 32'd0);
        reset = 1'b0;
        exp_valid = 1'b0;
        exp_overrun = 0;
        @(negedge clk);
        set_douts();
        run_cycle(2, 3, 8'h81, 1'b1, len);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
